// File: rtl/div_param_pkg.sv
// Shared constants for the parametrised restoring divider.
// Covers the state encodings and the handshake and reset levels.
package div_param_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DivFree   = 2'b00;
  localparam div_state_t DivByZero = 2'b01;
  localparam div_state_t DivOn     = 2'b10;
  localparam div_state_t DivEnd    = 2'b11;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic RstEnable = 1'b1;

endpackage

// File: rtl/div_param_if.sv
// Start/annul/ready handshake between the EX stage and the divider.
interface div_param_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               div_by_zero_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, div_by_zero_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, div_by_zero_o
  );
endinterface

// File: rtl/div_param_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  // The shifted remainder carries one extra bit so divisors with the MSB set
  // still compare correctly.
  logic [WIDTH:0] w_shift;
  logic           w_fits;

  assign w_shift = {i_rem, i_bit};
  assign w_fits  = (w_shift >= {1'b0, i_divisor});
  assign o_qbit  = w_fits;
  assign o_rem   = w_fits ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_param.sv
// Multi-cycle restoring divider for the EX stage, UNROLL quotient bits per clock.
// Result is {remainder, quotient}; the EX stage stalls until ready_o rises.
module div_param
  import div_param_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst,
  div_param_if.slave  div_bus
);

  localparam int STEPS = WIDTH / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);

  div_state_t         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_signed;
  logic               r_sign1;
  logic               r_sign2;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic               r_zero_flag;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_dbz;

  logic [WIDTH-1:0] w_op1_abs;
  logic [WIDTH-1:0] w_op2_abs;
  logic [WIDTH-1:0] w_rem [UNROLL+1];
  logic [WIDTH-1:0] w_quo [UNROLL+1];
  logic [WIDTH-1:0] w_rem_fix;
  logic [WIDTH-1:0] w_quo_fix;

  assign w_op1_abs = (div_bus.signed_div_i && div_bus.opdata1_i[WIDTH-1]) ?
                     -div_bus.opdata1_i : div_bus.opdata1_i;
  assign w_op2_abs = (div_bus.signed_div_i && div_bus.opdata2_i[WIDTH-1]) ?
                     -div_bus.opdata2_i : div_bus.opdata2_i;

  // The quotient register doubles as the dividend shifter: its MSB feeds each step.
  assign w_rem[0] = r_rem;
  assign w_quo[0] = r_quo;

  for (genvar k = 0; k < UNROLL; k++) begin : g_step
    logic w_qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem     (w_rem[k]),
      .i_bit     (w_quo[k][WIDTH-1]),
      .i_divisor (r_divisor),
      .o_rem     (w_rem[k+1]),
      .o_qbit    (w_qbit)
    );

    assign w_quo[k+1] = {w_quo[k][WIDTH-2:0], w_qbit};
  end

  // Remainder follows the dividend's sign; most-negative / -1 wraps naturally.
  assign w_quo_fix = (r_signed && (r_sign1 != r_sign2)) ? -r_quo : r_quo;
  assign w_rem_fix = (r_signed && r_sign1) ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state     <= DivFree;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_sign1     <= 1'b0;
      r_sign2     <= 1'b0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_zero_flag <= 1'b0;
      r_result    <= '0;
      r_ready     <= DivResultNotReady;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        DivFree: begin
          r_ready  <= DivResultNotReady;
          r_result <= '0;
          r_dbz    <= 1'b0;
          if (div_bus.start_i == DivStart && !div_bus.annul_i) begin
            r_signed    <= div_bus.signed_div_i;
            r_sign1     <= div_bus.opdata1_i[WIDTH-1];
            r_sign2     <= div_bus.opdata2_i[WIDTH-1];
            r_divisor   <= w_op2_abs;
            r_zero_flag <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= w_op1_abs;
            r_state     <= (div_bus.opdata2_i == '0) ? DivByZero : DivOn;
          end
        end
        DivByZero: begin
          r_rem       <= '0;
          r_quo       <= '0;
          r_zero_flag <= 1'b1;
          r_state     <= DivEnd;
        end
        DivOn: begin
          if (div_bus.annul_i) begin
            r_cnt   <= '0;
            r_state <= DivFree;
          end else if (r_cnt != CW'(STEPS)) begin
            r_rem <= w_rem[UNROLL];
            r_quo <= w_quo[UNROLL];
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_rem   <= w_rem_fix;
            r_quo   <= w_quo_fix;
            r_cnt   <= '0;
            r_state <= DivEnd;
          end
        end
        DivEnd: begin
          if (div_bus.start_i == DivStop) begin
            r_ready  <= DivResultNotReady;
            r_result <= '0;
            r_dbz    <= 1'b0;
            r_state  <= DivFree;
          end else begin
            r_result <= {r_rem, r_quo};
            r_ready  <= DivResultReady;
            r_dbz    <= r_zero_flag;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

  assign div_bus.result_o      = r_result;
  assign div_bus.ready_o       = r_ready;
  assign div_bus.div_by_zero_o = r_dbz;

endmodule

// File: tb/tb_div_param.sv
// Scoreboard bench: UNROLL=1/2/4 dividers driven side by side, checked against
// constants and a behavioural integer model, including per-variant latency.
module tb_div_param;

  localparam int W     = 32;
  localparam int LIMIT = 60;

  logic        clk;
  logic [2:0]  rst_v;
  logic [2:0]  start_v;
  logic [2:0]  annul_v;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  ready_v;
  logic [2:0]  dbz_v;
  logic [63:0] result_v [3];
  logic [64:0] exp_q [3][$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    div_param_if #(.WIDTH(W)) bus ();

    div_param #(.WIDTH(W), .UNROLL(1 << g)) u_dut (
      .clk     (clk),
      .rst     (rst_v[g]),
      .div_bus (bus)
    );

    assign bus.signed_div_i = signed_div;
    assign bus.opdata1_i    = op1;
    assign bus.opdata2_i    = op2;
    assign bus.start_i      = start_v[g];
    assign bus.annul_i      = annul_v[g];
    assign ready_v[g]       = bus.ready_o;
    assign dbz_v[g]         = bus.div_by_zero_o;
    assign result_v[g]      = bus.result_o;
  end

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // {div_by_zero, remainder, quotient}
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    if (b == 32'd0) return {1'b1, 64'd0};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uq = ua / ub;
    ur = ua % ub;
    return {1'b0, ur[31:0], uq[31:0]};
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [64:0] exp, input bit toggle, input bit rst_rel);
    bit [2:0]    done;
    int          lat [3];
    logic [64:0] e;
    @(negedge clk);
    op1 = a; op2 = b; signed_div = sgn;
    start_v = '1; annul_v = '0;
    for (int g = 0; g < 3; g++) begin
      exp_q[g].push_back(exp);
      lat[g] = exp[64] ? 2 : (32 >> g) + 2;
    end
    done = '0;
    @(posedge clk);
    @(negedge clk);
    if (toggle) begin
      op1 = $urandom; op2 = $urandom; signed_div = ~sgn;
    end
    for (int n = 1; n <= LIMIT && done != 3'b111; n++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!done[g] && ready_v[g]) begin
          done[g] = 1'b1;
          e = (exp_q[g].size() > 0) ? exp_q[g].pop_front() : '1;
          chk($sformatf("u%0d latency", 1 << g), 65'(n), 65'(lat[g]));
          chk($sformatf("u%0d result %h/%h s%0d", 1 << g, a, b, sgn),
              {dbz_v[g], result_v[g]}, e);
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      if (!done[g]) begin
        chk($sformatf("u%0d timeout ready", 1 << g), 65'(ready_v[g]), 65'd1);
        if (exp_q[g].size() > 0) void'(exp_q[g].pop_front());
      end
    end
    annul_v = '1;
    @(posedge clk);
    @(negedge clk);
    annul_v = '0;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("u%0d hold ready", 1 << g), 65'(ready_v[g]), 65'd1);
      chk($sformatf("u%0d hold result", 1 << g), {dbz_v[g], result_v[g]}, exp);
    end
    start_v = '0;
    if (rst_rel) rst_v = '1;
    @(posedge clk);
    @(negedge clk);
    rst_v = '0;
    for (int g = 0; g < 3; g++)
      chk($sformatf("u%0d release", 1 << g),
          {ready_v[g], dbz_v[g], result_v[g][62:0]}, 65'd0);
  endtask

  initial begin
    logic [2:0]  seen;
    int          kk [3];
    logic [31:0] a, b;
    logic        s;
    int          sel;

    clk = 1'b0; rst_v = '1; start_v = '0; annul_v = '0;
    signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("u%0d reset", 1 << g),
          {ready_v[g], dbz_v[g], result_v[g][62:0]}, 65'd0);
    rst_v = '0;

    run_txn(32'd7,        32'd2,        1'b0, {1'b0, 32'h00000001, 32'h00000003}, 0, 0);
    run_txn(32'hFFFFFFF9, 32'd2,        1'b1, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 0);
    run_txn(32'd7,        32'hFFFFFFFE, 1'b1, {1'b0, 32'h00000001, 32'hFFFFFFFD}, 0, 0);
    run_txn(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, {1'b0, 32'hFFFFFFFF, 32'h00000003}, 1, 0);
    run_txn(32'h80000000, 32'hFFFFFFFF, 1'b1, {1'b0, 32'h00000000, 32'h80000000}, 0, 0);
    run_txn(32'hFFFFFFFF, 32'd1,        1'b0, {1'b0, 32'h00000000, 32'hFFFFFFFF}, 0, 0);
    run_txn(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, {1'b0, 32'hFFFFFFFE, 32'h00000000}, 0, 0);
    run_txn(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, {1'b0, 32'h00000000, 32'h00000001}, 1, 0);
    run_txn(32'h12345678, 32'd0,        1'b0, {1'b1, 64'd0}, 0, 0);
    run_txn(32'h12345678, 32'd0,        1'b1, {1'b1, 64'd0}, 1, 1);

    // Annul mid-division: cnt=10 for UNROLL 1/2, cnt=4 for UNROLL 4 (still ON).
    kk = '{11, 11, 5};
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start_v = '1; seen = '0;
    @(posedge clk);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      seen |= ready_v;
      for (int g = 0; g < 3; g++) begin
        annul_v[g] = (n == kk[g]);
        if (n == kk[g]) start_v[g] = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    seen |= ready_v;
    annul_v = '0;
    for (int g = 0; g < 3; g++)
      chk($sformatf("u%0d annul no ready", 1 << g), 65'(seen[g]), 65'd0);
    run_txn(32'd100, 32'd7, 1'b0, {1'b0, 32'd2, 32'd14}, 0, 0);

    // Synchronous reset while all three are mid-division.
    @(negedge clk);
    op1 = 32'd1000; op2 = 32'd3; signed_div = 1'b0; start_v = '1; seen = '0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_v = '1; start_v = '0;
    @(posedge clk);
    @(negedge clk);
    rst_v = '0;
    for (int g = 0; g < 3; g++)
      chk($sformatf("u%0d mid-on reset", 1 << g),
          {ready_v[g], dbz_v[g], result_v[g][62:0]}, 65'd0);
    repeat (40) begin
      @(negedge clk);
      seen |= ready_v;
    end
    for (int g = 0; g < 3; g++)
      chk($sformatf("u%0d reset abandons", 1 << g), 65'(seen[g]), 65'd0);

    for (int i = 0; i < 1000; i++) begin
      s   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      a   = (sel == 9) ? 32'h80000000 : $urandom;
      case (sel)
        0:       b = 32'd0;
        1, 2, 3: b = (s && $urandom_range(0, 1) == 1) ? -32'($urandom_range(1, 255))
                                                      : 32'($urandom_range(1, 255));
        4:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_txn(a, b, s, model(a, b, s), 1, (i % 50) == 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
